// File: rtl/cic_pkg.sv
// Shared constants and config clamp helpers for the stereo PDM CIC decimator.
// Imported by cic_channel and the cic top level.
package cic_pkg;

   localparam int WIDTH     = 32;
   localparam int MAX_ORDER = 5;

   typedef logic [WIDTH-1:0] word_t;

   // Order 0 runs as 1, anything past MAX_ORDER as MAX_ORDER.
   function automatic logic [2:0] clamp_order(input logic [5:0] n);
      if (n == 6'd0)
         return 3'd1;
      else if (n > 6'(MAX_ORDER))
         return 3'(MAX_ORDER);
      else
         return n[2:0];
   endfunction

   // Ratio 0 runs as 1.
   function automatic logic [7:0] clamp_ratio(input logic [7:0] r);
      return (r == 8'd0) ? 8'd1 : r;
   endfunction

endpackage

// File: rtl/cic_channel.sv
// One CIC channel: N integrators, decimation counter, N combs (delay 1).
// Ports: strobe/x sample in, order/ratio config, fire pulse + sample out.
module cic_channel
   import cic_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       strobe,
   input  logic       x,
   input  logic [2:0] order,
   input  logic [7:0] ratio,
   output logic       fire,
   output word_t      sample
);

   word_t      integ_q [MAX_ORDER];
   word_t      integ_d [MAX_ORDER];
   word_t      dly_q   [MAX_ORDER];
   word_t      dly_d   [MAX_ORDER];
   logic [7:0] dec_cnt;
   word_t      acc;

   // Integrators cascade on the fresh values; combs run on the
   // just-updated top integrator so the result is ready this cycle.
   always_comb begin
      fire = strobe && (dec_cnt >= ratio - 8'd1);
      acc = integ_q[0] + word_t'(x);
      integ_d[0] = acc;
      for (int k = 1; k < MAX_ORDER; k++) begin
         if (k < int'(order)) begin
            acc = integ_q[k] + acc;
            integ_d[k] = acc;
         end else begin
            integ_d[k] = '0;
         end
      end
      for (int k = 0; k < MAX_ORDER; k++) begin
         if (k < int'(order)) begin
            dly_d[k] = acc;
            acc = acc - dly_q[k];
         end else begin
            dly_d[k] = '0;
         end
      end
      sample = acc;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < MAX_ORDER; k++) begin
            integ_q[k] <= '0;
            dly_q[k]   <= '0;
         end
         dec_cnt <= '0;
      end else if (strobe) begin
         for (int k = 0; k < MAX_ORDER; k++)
            integ_q[k] <= integ_d[k];
         if (fire) begin
            dec_cnt <= '0;
            for (int k = 0; k < MAX_ORDER; k++)
               dly_q[k] <= dly_d[k];
         end else begin
            dec_cnt <= dec_cnt + 8'd1;
         end
      end
   end

endmodule

// File: rtl/cic.sv
// Stereo PDM front end: bit-clock divider, L/R demux, two CIC decimators.
// Ports: clk/rst, clk_div/comb_num/dec_num config, data_in PDM, PCM out.
module cic
   import cic_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] clk_div,
   input  logic [5:0]  comb_num,
   input  logic [7:0]  dec_num,
   input  logic        data_in,
   output logic [31:0] data_out,
   output logic        data_out_valid,
   output logic        channel,
   output logic        clk_out
);

   logic [31:0] div_cnt;
   logic [31:0] lim;
   logic        toggle;
   logic        stb0;
   logic        stb1;
   logic        fire0;
   logic        fire1;
   word_t       smp0;
   word_t       smp1;
   logic [2:0]  order;
   logic [7:0]  ratio;

   assign order  = clamp_order(comb_num);
   assign ratio  = clamp_ratio(dec_num);
   assign lim    = (clk_div == 32'd0) ? 32'd1 : clk_div;
   assign toggle = (div_cnt == lim - 32'd1);
   // Rising bit clock samples right, falling samples left.
   assign stb1   = toggle && !clk_out;
   assign stb0   = toggle && clk_out;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
         clk_out <= 1'b0;
      end else if (toggle) begin
         div_cnt <= '0;
         clk_out <= ~clk_out;
      end else begin
         div_cnt <= div_cnt + 32'd1;
      end
   end

   cic_channel u_left (
      .clk    (clk),
      .rst    (rst),
      .strobe (stb0),
      .x      (data_in),
      .order  (order),
      .ratio  (ratio),
      .fire   (fire0),
      .sample (smp0)
   );

   cic_channel u_right (
      .clk    (clk),
      .rst    (rst),
      .strobe (stb1),
      .x      (data_in),
      .order  (order),
      .ratio  (ratio),
      .fire   (fire1),
      .sample (smp1)
   );

   // Strobes are never simultaneous, so a simple priority mux suffices.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out       <= '0;
         data_out_valid <= 1'b0;
         channel        <= 1'b0;
      end else begin
         data_out_valid <= fire0 || fire1;
         if (fire1) begin
            data_out <= smp1;
            channel  <= 1'b1;
         end else if (fire0) begin
            data_out <= smp0;
            channel  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cic.sv
// Randomized self-checking bench for cic against an impulse-response model.
// The model treats the CIC as N cascaded length-R box sums, then decimates.
module tb_cic;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] clk_div;
   logic [5:0]  comb_num;
   logic [7:0]  dec_num;
   logic        data_in;
   logic [31:0] data_out;
   logic        data_out_valid;
   logic        channel;
   logic        clk_out;

   cic dut (
      .clk            (clk),
      .rst            (rst),
      .clk_div        (clk_div),
      .comb_num       (comb_num),
      .dec_num        (dec_num),
      .data_in        (data_in),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .channel        (channel),
      .clk_out        (clk_out)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   int          lim;
   int          nn;
   int          rr;
   longint      h[$];
   bit          hist0[$];
   bit          hist1[$];
   int          edge_no;
   logic [31:0] last_data;
   logic        last_ch;
   logic [31:0] seq0[$];
   logic [31:0] seq1[$];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Impulse response of N cascaded boxes of length R.
   task automatic build_h();
      longint t[$];
      longint s;
      h = {};
      h.push_back(1);
      for (int st = 0; st < nn; st++) begin
         t = {};
         for (int i = 0; i < h.size() + rr - 1; i++) begin
            s = 0;
            for (int j = 0; j < rr; j++)
               if (i - j >= 0 && i - j < h.size())
                  s += h[i - j];
            t.push_back(s);
         end
         h = t;
      end
   endtask

   function automatic logic [31:0] ref_out(input int ch);
      longint s;
      int     n;
      s = 0;
      n = (ch == 1) ? hist1.size() : hist0.size();
      for (int j = 0; j < h.size() && j < n; j++)
         s += h[j] * ((ch == 1) ? longint'(hist1[n - 1 - j])
                                : longint'(hist0[n - 1 - j]));
      return s[31:0];
   endfunction

   task automatic apply_reset(input logic [31:0] cd, input logic [5:0] cn,
                              input logic [7:0] dn);
      @(negedge clk);
      rst      = 1'b1;
      clk_div  = cd;
      comb_num = cn;
      dec_num  = dn;
      data_in  = 1'b0;
      #1;
      chk("rst_data", data_out, 32'd0);
      chk("rst_valid", 32'(data_out_valid), 32'd0);
      chk("rst_clk_out", 32'(clk_out), 32'd0);
      chk("rst_channel", 32'(channel), 32'd0);
      lim = (cd == 0) ? 1 : int'(cd);
      nn  = (cn == 0) ? 1 : (cn > 5) ? 5 : int'(cn);
      rr  = (dn == 0) ? 1 : int'(dn);
      build_h();
      hist0 = {};
      hist1 = {};
      seq0  = {};
      seq1  = {};
      last_data = '0;
      last_ch   = 1'b0;
      repeat (2) @(negedge clk);
      rst     = 1'b0;
      edge_no = 0;
   endtask

   // mode: 0 random, 1 ones, 2 zeros, 3 high-phase ones
   task automatic run(input int cycles, input int mode);
      bit dv;
      bit ev;
      bit ch;
      int k;
      int n;
      for (int c = 0; c < cycles; c++) begin
         dv = data_in;
         @(posedge clk);
         edge_no++;
         ev = 1'b0;
         if (edge_no % lim == 0) begin
            k  = edge_no / lim;
            ch = (k % 2) == 1;
            if (ch) begin
               hist1.push_back(dv);
               n = hist1.size();
            end else begin
               hist0.push_back(dv);
               n = hist0.size();
            end
            if (n % rr == 0) begin
               ev        = 1'b1;
               last_ch   = ch;
               last_data = ref_out(ch ? 1 : 0);
               if (ch) seq1.push_back(last_data);
               else    seq0.push_back(last_data);
            end
         end
         @(negedge clk);
         chk("valid", 32'(data_out_valid), 32'(ev));
         chk("clk_out", 32'(clk_out), 32'((edge_no / lim) % 2));
         chk("data_out", data_out, last_data);
         chk("channel", 32'(channel), 32'(last_ch));
         case (mode)
            0: data_in = 1'($urandom_range(0, 1));
            1: data_in = 1'b1;
            2: data_in = 1'b0;
            default: data_in = 1'((edge_no / lim) % 2);
         endcase
      end
   endtask

   task automatic chk_seq_20_60_64();
      chk("seq_len0", 32'(seq0.size() >= 3), 32'd1);
      chk("seq_len1", 32'(seq1.size() >= 3), 32'd1);
      if (seq0.size() >= 3) begin
         chk("seq0_a", seq0[0], 32'd20);
         chk("seq0_b", seq0[1], 32'd60);
         chk("seq0_c", seq0[2], 32'd64);
      end
      if (seq1.size() >= 3) begin
         chk("seq1_a", seq1[0], 32'd20);
         chk("seq1_b", seq1[1], 32'd60);
         chk("seq1_c", seq1[2], 32'd64);
      end
   endtask

   initial begin
      rst      = 1'b1;
      clk_div  = 32'd2;
      comb_num = 6'd3;
      dec_num  = 8'd1;
      data_in  = 1'b0;

      apply_reset(32'd2, 6'd3, 8'd1);
      run(40, 1);

      apply_reset(32'd2, 6'd3, 8'd4);
      run(120, 1);
      chk_seq_20_60_64();

      apply_reset(32'd3, 6'd2, 8'd5);
      run(80, 2);

      apply_reset(32'd0, 6'd0, 8'd0);
      run(80, 0);

      apply_reset(32'd2, 6'd3, 8'd4);
      run(45, 1);
      apply_reset(32'd2, 6'd3, 8'd4);
      run(120, 1);
      chk_seq_20_60_64();

      apply_reset(32'd2, 6'd2, 8'd8);
      run(300, 3);
      if (seq0.size() > 0)
         chk("alt_ch0", seq0[seq0.size() - 1], 32'd64);
      else
         chk("alt_ch0_none", 32'd0, 32'd64);
      if (seq1.size() > 0)
         chk("alt_ch1", seq1[seq1.size() - 1], 32'd0);
      else
         chk("alt_ch1_none", 32'd1, 32'd0);

      apply_reset(32'd1, 6'd9, 8'd3);
      run(200, 0);

      for (int i = 0; i < 3; i++) begin
         apply_reset(32'($urandom_range(0, 4)), 6'($urandom_range(0, 7)),
                     8'($urandom_range(0, 10)));
         run(250, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
